// File: rtl/gfx_pixel_unpacker.sv
// Framebuffer read-side unpacker: takes 128-bit memory words and streams one
// pixel per clock, expanded to 1-10-10-10 ARGB.
module gfx_pixel_unpacker #(
  parameter int unsigned WORD_WIDTH = 128,
  parameter int unsigned PointWidth = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  start_i,
  input  logic [1:0]            depth_i,
  input  logic [PointWidth-1:0] npix_i,
  input  logic [WORD_WIDTH-1:0] wd_i,
  input  logic                  wvalid_i,
  output logic                  wready_o,
  output logic                  pvalid_o,
  input  logic                  pready_i,
  output logic                  a_o,
  output logic [9:0]            r_o,
  output logic [9:0]            g_o,
  output logic [9:0]            b_o,
  output logic [PointWidth-1:0] px_o,
  output logic                  plast_o,
  output logic                  busy_o,
  output logic                  done_o
);

  localparam int unsigned CntW = PointWidth + 1;

  typedef enum logic [1:0] {Bpp8 = 2'd0, Bpp16 = 2'd1, Bpp24 = 2'd2, Bpp32 = 2'd3} depth_e;
  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e                r_state, w_state_next;
  logic [1:0]            r_depth;
  logic [PointWidth-1:0] r_npix, r_words_rem, r_load_cnt, w_words_start;
  logic [WORD_WIDTH-1:0] r_buf;
  logic                  r_buf_valid;
  logic [3:0]            r_sidx, w_sidx_max;
  logic                  r_pvalid, r_a, r_plast;
  logic [9:0]            r_r, r_g, r_b;
  logic [PointWidth-1:0] r_px;

  logic [CntW-1:0]       w_np;
  logic [6:0]            w_shift;
  logic [31:0]           w_pix;
  logic                  w_a;
  logic [9:0]            w_r, w_g, w_b;
  logic                  w_load, w_last_pix, w_buf_last, w_wready, w_accept, w_final_xfer;

  // Word count for the run, ceil(npix / pixels-per-word).
  always_comb begin
    w_np = {1'b0, npix_i};
    w_words_start = '0;
    unique case (depth_e'(depth_i))
      Bpp8:  w_words_start = PointWidth'((w_np + CntW'(15)) >> 4);
      Bpp16: w_words_start = PointWidth'((w_np + CntW'(7)) >> 3);
      Bpp24: w_words_start = PointWidth'((w_np + CntW'(4)) / CntW'(5));
      Bpp32: w_words_start = PointWidth'((w_np + CntW'(3)) >> 2);
    endcase
  end

  always_comb begin
    w_sidx_max = 4'd0;
    w_shift    = 7'd0;
    unique case (depth_e'(r_depth))
      Bpp8:  begin w_sidx_max = 4'd15; w_shift = {r_sidx, 3'b000};         end
      Bpp16: begin w_sidx_max = 4'd7;  w_shift = {r_sidx[2:0], 4'b0000};   end
      Bpp24: begin w_sidx_max = 4'd4;  w_shift = 7'(r_sidx) * 7'd24;       end
      Bpp32: begin w_sidx_max = 4'd3;  w_shift = {r_sidx[1:0], 5'b00000};  end
    endcase
  end

  assign w_pix = 32'(r_buf >> w_shift);

  // Channel expansion replicates the field MSBs into the low bits.
  always_comb begin
    w_a = 1'b0;
    w_r = '0;
    w_g = '0;
    w_b = '0;
    unique case (depth_e'(r_depth))
      Bpp8: begin
        w_a = 1'b1;
        w_r = {w_pix[7:5], w_pix[7:5], w_pix[7:5], w_pix[7]};
        w_g = {w_pix[4:2], w_pix[4:2], w_pix[4:2], w_pix[4]};
        w_b = {5{w_pix[1:0]}};
      end
      Bpp16: begin
        w_a = w_pix[15];
        w_r = {2{w_pix[14:10]}};
        w_g = {2{w_pix[9:5]}};
        w_b = {2{w_pix[4:0]}};
      end
      Bpp24: begin
        w_a = w_pix[23];
        w_r = {w_pix[22:15], w_pix[22:21]};
        w_g = {w_pix[14:7], w_pix[14:13]};
        w_b = {w_pix[6:0], w_pix[6:4]};
      end
      Bpp32: begin
        w_a = w_pix[31];
        w_r = w_pix[30:21];
        w_g = w_pix[20:11];
        w_b = w_pix[9:0];
      end
    endcase
  end

  assign w_last_pix   = (r_load_cnt == r_npix - PointWidth'(1));
  assign w_load       = (r_state == StRun) && r_buf_valid && (!r_pvalid || pready_i);
  assign w_buf_last   = (r_sidx == w_sidx_max) || w_last_pix;
  assign w_wready     = (r_state == StRun) && (r_words_rem != '0) &&
                        (!r_buf_valid || (w_load && w_buf_last));
  assign w_accept     = wvalid_i && w_wready;
  assign w_final_xfer = r_pvalid && r_plast && pready_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= StIdle;
    else         r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:  if (start_i) w_state_next = (npix_i != '0) ? StRun : StDone;
      StRun:   if (w_final_xfer) w_state_next = StDone;
      StDone:  w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  always_comb begin
    busy_o   = (r_state == StRun) || (r_state == StDone);
    done_o   = (r_state == StDone);
    wready_o = w_wready;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_depth     <= '0;
      r_npix      <= '0;
      r_words_rem <= '0;
      r_load_cnt  <= '0;
      r_buf       <= '0;
      r_buf_valid <= 1'b0;
      r_sidx      <= '0;
      r_pvalid    <= 1'b0;
      r_a         <= 1'b0;
      r_r         <= '0;
      r_g         <= '0;
      r_b         <= '0;
      r_px        <= '0;
      r_plast     <= 1'b0;
    end else if (r_state == StIdle && start_i) begin
      r_depth     <= depth_i;
      r_npix      <= npix_i;
      r_words_rem <= w_words_start;
      r_load_cnt  <= '0;
      r_buf_valid <= 1'b0;
      r_sidx      <= '0;
    end else begin
      // Accept only happens with an empty buffer or when its last pixel leaves.
      if (w_accept) begin
        r_buf       <= wd_i;
        r_buf_valid <= 1'b1;
        r_sidx      <= '0;
        r_words_rem <= r_words_rem - PointWidth'(1);
      end else if (w_load && w_buf_last) begin
        r_buf_valid <= 1'b0;
      end else if (w_load) begin
        r_sidx <= r_sidx + 4'd1;
      end
      if (w_load) begin
        r_pvalid   <= 1'b1;
        r_a        <= w_a;
        r_r        <= w_r;
        r_g        <= w_g;
        r_b        <= w_b;
        r_px       <= r_load_cnt;
        r_plast    <= w_last_pix;
        r_load_cnt <= r_load_cnt + PointWidth'(1);
      end else if (r_pvalid && pready_i) begin
        r_pvalid <= 1'b0;
      end
    end
  end

  assign pvalid_o = r_pvalid;
  assign a_o      = r_a;
  assign r_o      = r_r;
  assign g_o      = r_g;
  assign b_o      = r_b;
  assign px_o     = r_px;
  assign plast_o  = r_plast && r_pvalid;

endmodule

// File: tb/tb_gfx_pixel_unpacker.sv
// Scoreboard bench for gfx_pixel_unpacker: directed words per colour depth,
// expected pixels queued up front and checked by an independent monitor.
module tb_gfx_pixel_unpacker;

  logic         clk_i, rst_ni, start_i, wvalid_i, wready_o, pvalid_o, pready_i;
  logic [1:0]   depth_i;
  logic [15:0]  npix_i, px_o;
  logic [127:0] wd_i;
  logic         a_o, plast_o, busy_o, done_o;
  logic [9:0]   r_o, g_o, b_o;

  gfx_pixel_unpacker dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .depth_i(depth_i),
    .npix_i(npix_i), .wd_i(wd_i), .wvalid_i(wvalid_i), .wready_o(wready_o),
    .pvalid_o(pvalid_o), .pready_i(pready_i), .a_o(a_o), .r_o(r_o), .g_o(g_o),
    .b_o(b_o), .px_o(px_o), .plast_o(plast_o), .busy_o(busy_o), .done_o(done_o)
  );

  int checks = 0, errors = 0, cyc = 0;
  int done_cnt = 0, done_cyc = -1, plast_cyc = -1, first_cyc = -1, last_cyc = -1;
  int accepted = 0, acc_base = 0, run_exp_words = 0, wr_extra = 0;
  logic [47:0]  exp_q[$];
  logic [127:0] wq[$];

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic logic [47:0] pxe(input logic a, input logic [9:0] r, input logic [9:0] g,
                                      input logic [9:0] b, input int idx, input logic last);
    return {a, r, g, b, 16'(idx), last};
  endfunction

  // Word driver: offers queued words, counts acceptances and stray wready.
  initial begin
    wvalid_i = 1'b0;
    wd_i     = '0;
    forever begin
      @(negedge clk_i);
      if (wq.size() > 0) begin wvalid_i = 1'b1; wd_i = wq[0]; end
      else begin wvalid_i = 1'b0; wd_i = '0; end
      #4;
      if (wready_o && (accepted - acc_base) >= run_exp_words) wr_extra++;
      if (wvalid_i && wready_o) begin
        void'(wq.pop_front());
        accepted++;
      end
    end
  end

  // Monitor: every presented pixel must match the scoreboard head.
  initial begin
    forever begin
      @(negedge clk_i);
      #4;
      cyc++;
      if (done_o) begin done_cnt++; done_cyc = cyc; end
      if (pvalid_o) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_pixel actual=px%0d required=none", px_o);
        end else begin
          check("pixel", {a_o, r_o, g_o, b_o, px_o, plast_o}, exp_q[0]);
          if (pready_i) begin
            void'(exp_q.pop_front());
            if (first_cyc < 0) first_cyc = cyc;
            last_cyc = cyc;
            if (plast_o) plast_cyc = cyc;
          end
        end
      end
    end
  end

  task automatic run_pix(input logic [1:0] d, input logic [15:0] n, input int exp_words,
                         input int stall_at, input int restart_at);
    int db, snap, start_cyc;
    bit got;
    snap = 0;
    @(negedge clk_i);
    depth_i = d; npix_i = n; start_i = 1'b1;
    db = done_cnt; acc_base = accepted; run_exp_words = exp_words; wr_extra = 0;
    first_cyc = -1; last_cyc = -1; plast_cyc = -1; start_cyc = cyc;
    @(negedge clk_i);
    start_i = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (stall_at >= 0 && i == stall_at) begin snap = accepted; pready_i = 1'b0; end
      if (stall_at >= 0 && i == stall_at + 3) begin
        pready_i = 1'b1;
        check("stall_no_accept", accepted, snap);
      end
      if (restart_at >= 0 && i == restart_at) begin
        start_i = 1'b1; depth_i = 2'd0; npix_i = 16'd3;
      end
      if (restart_at >= 0 && i == restart_at + 1) start_i = 1'b0;
      if (done_cnt != db) begin got = 1'b1; break; end
      @(negedge clk_i);
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL run_timeout actual=no_done required=done");
    end
    check("words_accepted", accepted - acc_base, exp_words);
    check("pixels_left", exp_q.size(), 0);
    check("wready_after_last", wr_extra, 0);
    if (n != 0) check("done_latency", done_cyc, plast_cyc + 1);
    else        check("done_latency_empty", done_cyc, start_cyc + 2);
    if (stall_at < 0 && n != 0) check("burst_len", last_cyc - first_cyc, int'(n) - 1);
    @(negedge clk_i);
    check("idle_after_done", {busy_o, done_o, pvalid_o}, 0);
    check("done_once", done_cnt - db, 1);
    wq.delete();
    exp_q.delete();
    pready_i = 1'b1;
  endtask

  task automatic push_bpp16_run;
    wq.push_back({16'h5555, 80'h0, 16'h8000, 16'h7FFF});
    exp_q.push_back(pxe(1'b0, 10'h3FF, 10'h3FF, 10'h3FF, 0, 1'b0));
    exp_q.push_back(pxe(1'b1, 10'h000, 10'h000, 10'h000, 1, 1'b0));
    for (int k = 2; k < 7; k++) exp_q.push_back(pxe(1'b0, 10'h0, 10'h0, 10'h0, k, 1'b0));
    exp_q.push_back(pxe(1'b0, 10'h2B5, 10'h14A, 10'h2B5, 7, 1'b1));
  endtask

  initial begin
    int db;
    rst_ni = 1'b0; start_i = 1'b0; pready_i = 1'b1; depth_i = '0; npix_i = '0;
    repeat (3) @(negedge clk_i);
    check("reset_outputs",
          {pvalid_o, wready_o, busy_o, done_o, plast_o, a_o, r_o, g_o, b_o, px_o}, 0);
    rst_ni = 1'b1;

    // BPP16, one word, plus an ignored start while busy.
    push_bpp16_run();
    run_pix(2'd1, 16'd8, 1, -1, 3);

    // BPP24 across two words; top byte of word0 and tail of word1 ignored.
    wq.push_back({8'hFF, 96'h0, 24'hFFFFFF});
    wq.push_back({8'h00, {3{24'hFFFFFF}}, 24'h80007F, 24'h400080});
    wq.push_back({16{8'hAA}});
    exp_q.push_back(pxe(1'b1, 10'h3FF, 10'h3FF, 10'h3FF, 0, 1'b0));
    for (int k = 1; k < 5; k++) exp_q.push_back(pxe(1'b0, 10'h0, 10'h0, 10'h0, k, 1'b0));
    exp_q.push_back(pxe(1'b0, 10'h202, 10'h004, 10'h000, 5, 1'b0));
    exp_q.push_back(pxe(1'b1, 10'h000, 10'h000, 10'h3FF, 6, 1'b1));
    run_pix(2'd2, 16'd7, 2, -1, -1);

    // BPP32 with a 3-cycle consumer stall on the first pixel.
    wq.push_back({64'h0, 32'h8000_0001, 32'h7FFF_FC00});
    wq.push_back({32'hFFFF_FFFF, 96'h0});
    exp_q.push_back(pxe(1'b0, 10'h3FF, 10'h3FF, 10'h000, 0, 1'b0));
    exp_q.push_back(pxe(1'b1, 10'h000, 10'h000, 10'h001, 1, 1'b0));
    for (int k = 2; k < 7; k++) exp_q.push_back(pxe(1'b0, 10'h0, 10'h0, 10'h0, k, 1'b0));
    exp_q.push_back(pxe(1'b1, 10'h3FF, 10'h3FF, 10'h3FF, 7, 1'b1));
    run_pix(2'd3, 16'd8, 2, 2, -1);

    // BPP8, 20 pixels back to back across a word boundary.
    wq.push_back({{15{8'h00}}, 8'hE3});
    wq.push_back({{12{8'hAA}}, 8'hFF, 8'h00, 8'h00, 8'h24});
    exp_q.push_back(pxe(1'b1, 10'h3FF, 10'h000, 10'h3FF, 0, 1'b0));
    for (int k = 1; k < 16; k++) exp_q.push_back(pxe(1'b1, 10'h0, 10'h0, 10'h0, k, 1'b0));
    exp_q.push_back(pxe(1'b1, 10'h092, 10'h092, 10'h000, 16, 1'b0));
    exp_q.push_back(pxe(1'b1, 10'h0, 10'h0, 10'h0, 17, 1'b0));
    exp_q.push_back(pxe(1'b1, 10'h0, 10'h0, 10'h0, 18, 1'b0));
    exp_q.push_back(pxe(1'b1, 10'h3FF, 10'h3FF, 10'h3FF, 19, 1'b1));
    run_pix(2'd0, 16'd20, 2, -1, -1);

    // Empty run: immediate done, no word requested.
    wq.push_back({8{16'h1234}});
    run_pix(2'd1, 16'd0, 0, -1, -1);

    // Reset in the middle of a run.
    push_bpp16_run();
    @(negedge clk_i);
    depth_i = 2'd1; npix_i = 16'd8; start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    repeat (3) @(negedge clk_i);
    check("pre_reset_streaming", pvalid_o, 1'b1);
    #2;
    rst_ni = 1'b0;
    #1;
    check("async_reset_outputs",
          {pvalid_o, wready_o, busy_o, done_o, plast_o, a_o, r_o, g_o, b_o, px_o}, 0);
    exp_q.delete();
    wq.delete();
    db = done_cnt;
    repeat (3) @(negedge clk_i);
    check("no_done_on_reset", done_cnt, db);
    rst_ni = 1'b1;

    wq.push_back({112'h0, 16'h8000});
    exp_q.push_back(pxe(1'b1, 10'h0, 10'h0, 10'h0, 0, 1'b1));
    run_pix(2'd1, 16'd1, 1, -1, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/gfx_pixel_unpacker.md
Name: gfx_pixel_unpacker

Overview:
- Read-side counterpart to the framebuffer pixel packer.
- Accepts 128-bit memory words from the display/blit fetch path and streams out one pixel per clock, expanded to a common 1-10-10-10 ARGB form.
- Supports all four color_depth_t formats from gfx_pkg.
- Sits between the memory read burst engine and the blitter/scanline pipeline.

Parameters:
- WORD_WIDTH, 128, memory word width; only 128 is supported.
- point_width, gfx_pkg::point_width (16), width of pixel count and x index.

Ports:
- clk_i  input  1  clock
- rst_ni  input  1  asynchronous active-low reset
- start_i  input  1  begin a run; sampled in IDLE only
- depth_i  input  2  color_depth_t; latched on start
- npix_i  input  point_width  pixels in the run; latched on start
- wd_i  input  128  memory word
- wvalid_i  input  1  word valid
- wready_o  output  1  word accepted when wvalid_i&&wready_o
- pvalid_o  output  1  pixel valid
- pready_i  input  1  pixel consumer ready
- a_o  output  1  alpha bit
- r_o, g_o, b_o  output  10 each  expanded color
- px_o  output  point_width  pixel index within run (0..npix-1)
- plast_o  output  1  final pixel of run
- busy_o  output  1  run in progress
- done_o  output  1  one-cycle pulse after final pixel transfer

Behaviour:
- Reset: all outputs 0; FSM=IDLE; word buffer empty; counters 0. Reset mid-run discards the buffered word and output pixel; no done_o.
- FSM states:
  - IDLE: start_i → RUN if npix_i≠0, else DONE.
  - RUN: final pixel handshake (plast_o&&pvalid_o&&pready_i) → DONE.
  - DONE: assert done_o for one cycle → IDLE.
- busy_o=1 in RUN and DONE. start_i is ignored outside IDLE.
- Pixels per word (PPW):
  - BPP8=16, BPP16=8, BPP24=5, BPP32=4.
  - Pixel k occupies bits [k*bpp +: bpp], LSB first.
  - BPP24 ignores wd_i[127:120].
- Field decode and expansion:
  - BPP8 3-3-2: R[7:5], G[4:2], B[1:0]; A=1. R,G = {x,x,x,x[2]}; B = {x,x,x,x,x}.
  - BPP16 1-5-5-5: A[15], R[14:10], G[9:5], B[4:0]. Each channel = {x,x}.
  - BPP24 1-8-8-7: A[23], R[22:15], G[14:7], B[6:0]. R,G = {x,x[7:6]}; B = {x,x[6:4]}.
  - BPP32 1-10-11-10: A[31], R[30:21], G[20:10], B[9:0]. R,B pass through; G = x[10:1].
- Structure:
  - One 128-bit word buffer with sub-index sidx (0..PPW-1).
  - One registered output pixel stage.
- Output stage:
  - Loads when (!pvalid_o || pready_i) and the buffer holds a pixel.
  - Holds all outputs stable while pvalid_o && !pready_i.
- Buffer:
  - wready_o = RUN && words_remaining≠0 && (buffer empty || final needed pixel of buffer loads into output stage this cycle).
  - A word accepted on edge e yields its first pixel on pvalid_o after edge e+1.
  - Sustained throughput is 1 pixel/clk when wvalid_i is held high.
- Counting:
  - words_needed = ceil(npix/PPW), computed at start.
  - Pixels beyond npix in the final word are discarded.
  - No word is requested after the last needed word.
- Output metadata:
  - px_o increments by 1 per loaded pixel.
  - plast_o = (px_o == npix-1) with pvalid_o.
- pvalid_o drops when the output transfers and no buffered pixel is available.
- Same-edge case: the final pixel of the buffer loads and a new word is accepted on the same edge. The next load takes pixel 0 of the new word; no bubble, no duplicate.

Test Plan:
- BPP16, npix=8, wd_i word with pixel0=16'h7FFF, pixel1=16'h8000, pready_i=1:
  - 8 pixels on 8 consecutive cycles.
  - px0: a=0, r=g=b=10'h3FF. px1: a=1, rgb=0.
  - plast_o on px7; done_o one cycle later.
  - Exactly one word accepted.
- BPP24, npix=7, two words:
  - pixel 5 comes from word1 bits[23:0].
  - wd_i[127:120]=8'hFF in word0 has no effect.
  - Pixels 7..9 of word1 dropped.
  - wready_o never asserts after the second word.
- BPP32, pixel=32'h7FFFFC00:
  - r=10'h3FF, g=10'h3FF, b=0.
  - Stall pready_i=0 for 3 cycles mid-run: outputs stable, no word accepted while the buffer is full.
- BPP8, npix=20, wvalid_i held high:
  - 20 back-to-back pixels, no bubble at the word boundary.
  - pixel 8'hE3 → r=10'h3FF, g=0, b=10'h3FF, a=1.
- npix=0 start → done_o pulses the next cycle, wready_o stays 0.
- start_i while busy → ignored.
- rst_ni low mid-run, then a new run:
  - All outputs go 0 asynchronously.
  - A following BPP16 npix=1 run completes normally.
